// File: rtl/dvi_timing_ctrl_pkg.sv
// dvi_pkg: shared FSM states, TMDS control codes, 640x480@60 timing defaults and pixel type
package dvi_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
  localparam logic [9:0] TMDS_CTL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTL_11 = 10'b1010101011;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;
  function automatic rgb24_t bar_color(input logic [2:0] i);
    return '{r: {8{~i[1]}}, g: {8{~i[2]}}, b: {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// dvi_timing_ctrl_if: pixel request handshake from the source plus the video bus to the TMDS encoders
interface dvi_timing_ctrl_if;
  import dvi_pkg::*;
  logic pix_req;
  logic pix_valid;
  rgb24_t rgb_in;
  rgb24_t rgb_out;
  logic [12:0] x_pos;
  logic [12:0] y_pos;
  logic vde;
  logic hsync;
  logic vsync;
  logic [1:0] ctl_b;
  logic [1:0] ctl_g;
  logic [1:0] ctl_r;
  modport master (
    output pix_req, rgb_out, x_pos, y_pos, vde, hsync, vsync, ctl_b, ctl_g, ctl_r,
    input pix_valid, rgb_in
  );
  modport slave (
    input pix_req, rgb_out, x_pos, y_pos, vde, hsync, vsync, ctl_b, ctl_g, ctl_r,
    output pix_valid, rgb_in
  );
endinterface

// File: rtl/dvi_axis_counter.sv
// dvi_axis_counter: one timing axis (H or V) with active, sync and last-position decode
module dvi_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP = 16,
  parameter int SYNC = 96,
  parameter int BP = 48
) (
  input logic clk,
  input logic rst,
  input logic step,
  input logic clear,
  output logic [12:0] pos,
  output logic active,
  output logic sync,
  output logic last
);
  localparam logic [12:0] SYNC_LO = 13'(ACTIVE + FP);
  localparam logic [12:0] SYNC_HI = 13'(ACTIVE + FP + SYNC);
  localparam logic [12:0] LAST = 13'(ACTIVE + FP + SYNC + BP - 1);
  if (ACTIVE < 1) begin : g_bad_active
    $error("dvi_axis_counter: ACTIVE must be at least 1");
  end
  // position advances on step and wraps after the axis' last position
  always_ff @(posedge clk) pos <= (rst || clear) ? '0 : step ? (last ? '0 : pos + 13'd1) : pos;
  assign active = pos < 13'(ACTIVE);
  assign sync = pos >= SYNC_LO && pos < SYNC_HI;
  assign last = pos == LAST;
endmodule

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: DVI timing sequencer with lookahead pixel request; DVI_TEST_PATTERN_EN adds tp_sel colour bars
module dvi_timing_ctrl import dvi_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic rst,
  input logic en,
`ifdef DVI_TEST_PATTERN_EN
  input logic tp_sel,
`endif
  dvi_timing_ctrl_if.master vid,
  output logic frame_start,
  output logic underflow,
  output logic busy
);
  state_t state, next_state;
  logic go, act, at_end, hact, vact, hsy, vsy, hlast, vlast, hs_lvl, vs_lvl;
  logic [12:0] hpos, vpos;
  rgb24_t pix;
`ifdef DVI_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1;
  logic [12:0] bar;
  assign bar = hpos / 13'(BAR_W);
`endif
  dvi_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst(rst), .step(go), .clear(!go),
    .pos(hpos), .active(hact), .sync(hsy), .last(hlast)
  );
  dvi_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst(rst), .step(go && hlast), .clear(!go),
    .pos(vpos), .active(vact), .sync(vsy), .last(vlast)
  );
  // state register; counters run one pixel ahead, so at_end flags the frame's final output cycle
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : next_state;
    at_end <= go && hlast && vlast;
  end
  // STOP_PEND leaves only at the frame's last output cycle, restarting without a gap if en is back
  always_comb next_state = state == IDLE ? (en ? RUN : IDLE) : state == RUN ? (en ? RUN : STOP_PEND) : at_end ? (en ? RUN : IDLE) : STOP_PEND;
  // go means the next cycle shows a timing position, so the counter position is requested and captured now
  always_comb begin
    busy = state != IDLE;
    go = !rst && next_state != IDLE;
    act = hact && vact;
    hs_lvl = hsy ? SYNC_POL : !SYNC_POL;
    vs_lvl = vsy ? SYNC_POL : !SYNC_POL;
`ifdef DVI_TEST_PATTERN_EN
    vid.pix_req = go && act && !tp_sel;
    pix = (tp_sel && go && act) ? bar_color(bar > 13'd7 ? 3'd7 : bar[2:0]) : (vid.pix_req && vid.pix_valid) ? vid.rgb_in : '0;
`else
    vid.pix_req = go && act;
    pix = (vid.pix_req && vid.pix_valid) ? vid.rgb_in : '0;
`endif
  end
  // aligned video outputs; idle and reset present the same deasserted values
  always_ff @(posedge clk) begin
    if (rst || !go) begin
      vid.x_pos <= '0;
      vid.y_pos <= '0;
      vid.vde <= 1'b0;
      vid.hsync <= !SYNC_POL;
      vid.vsync <= !SYNC_POL;
      vid.ctl_b <= 2'b00;
      vid.rgb_out <= '0;
      frame_start <= 1'b0;
    end else begin
      vid.x_pos <= hpos;
      vid.y_pos <= vpos;
      vid.vde <= act;
      vid.hsync <= hs_lvl;
      vid.vsync <= vs_lvl;
      vid.ctl_b <= {vs_lvl, hs_lvl};
      vid.rgb_out <= pix;
      frame_start <= hpos == 13'd0 && vpos == 13'd0;
    end
  end
  // sticky record of any request the source could not serve
  always_ff @(posedge clk) underflow <= rst ? 1'b0 : underflow || (vid.pix_req && !vid.pix_valid);
  assign vid.ctl_g = 2'b00;
  assign vid.ctl_r = 2'b00;
endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl: randomized bench against a frame-index reference model on a reduced timing set
module tb_dvi_timing_ctrl;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;
  logic clk = 1'b0;
  logic rst, en, frame_start, underflow, busy;
`ifdef DVI_TEST_PATTERN_EN
  logic tp_sel = 1'b0;
`endif
  dvi_timing_ctrl_if vif ();
  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
`ifdef DVI_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .vid(vif),
    .frame_start(frame_start),
    .underflow(underflow),
    .busy(busy)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  bit m_on, m_stop, m_uf, m_fs;
  int m_p;
  logic [23:0] m_rgb;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic observe();
    int x, y;
    bit hs_a, vs_a;
    x = m_p % HT;
    y = m_p / HT;
    hs_a = x >= HA + HFP && x < HA + HFP + HS;
    vs_a = y >= VA + VFP && y < VA + VFP + VS;
    chk("x_pos", vif.x_pos, m_on ? x : 0);
    chk("y_pos", vif.y_pos, m_on ? y : 0);
    chk("vde", vif.vde, m_on && x < HA && y < VA);
    chk("hsync", vif.hsync, !(m_on && hs_a));
    chk("vsync", vif.vsync, !(m_on && vs_a));
    chk("ctl_b", vif.ctl_b, m_on ? {30'd0, !vs_a, !hs_a} : 0);
    chk("ctl_gr", {vif.ctl_g, vif.ctl_r}, 0);
    chk("rgb_out", vif.rgb_out, m_rgb);
    chk("frame_start", frame_start, m_fs);
    chk("underflow", underflow, m_uf);
    chk("busy", busy, m_on);
  endtask
  // pv_mode: 0 always valid, 1 invalid only for frame index drop_p, 2 random
  task automatic step(input bit r, input bit e, input int pv_mode, input int drop_p);
    bit last, n_on, n_stop, req, pv;
    int n_p;
    logic [23:0] d;
    @(negedge clk);
    observe();
    last = m_on && m_p == FR - 1;
    n_p = 0;
    if (r) n_on = 0;
    else if (!m_on) n_on = e;
    else if (!m_stop || !last) begin
      n_on = 1;
      n_p = (m_p + 1) % FR;
    end else n_on = e;
    n_stop = (!r && m_on && n_on && !(m_stop && last)) ? (m_stop || !e) : 0;
    req = n_on && (n_p % HT) < HA && (n_p / HT) < VA;
    pv = pv_mode == 0 ? 1'b1 : pv_mode == 1 ? !(n_on && n_p == drop_p) : ($urandom_range(0, 5) != 0);
    d = 24'($urandom);
    rst = r;
    en = e;
    vif.pix_valid = pv;
    vif.rgb_in = d;
    #1;
    chk("pix_req", vif.pix_req, req);
    m_rgb = (req && pv) ? d : 24'h0;
    m_uf = r ? 0 : (m_uf || (req && !pv));
    m_fs = n_on && n_p == 0;
    m_on = n_on;
    m_p = n_p;
    m_stop = n_stop;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    int fs_t[$];
    int nfs, vde_n;
    rst = 1'b1;
    en = 1'b0;
    vif.pix_valid = 1'b0;
    vif.rgb_in = '0;
    repeat (2) @(posedge clk);
    m_on = 0; m_stop = 0; m_uf = 0; m_fs = 0; m_p = 0; m_rgb = 0;
    repeat (2) step(1, 0, 0, -1);
    nfs = 0;
    vde_n = 0;
    for (int i = 0; i < 2 * FR + 1; i++) begin
      step(0, 1, 0, -1);
      if (frame_start) begin
        fs_t.push_back(i);
        nfs++;
      end
      if (nfs == 1 && vif.vde) vde_n++;
    end
    chk("fs_count", fs_t.size(), 2);
    if (fs_t.size() >= 2) chk("fs_gap", fs_t[1] - fs_t[0], FR);
    chk("vde_per_frame", vde_n, HA * VA);
    chk("no_underflow", underflow, 0);
    for (int i = 0; i < FR; i++) step(0, 1, 1, 3 * HT + 10);
    chk("underflow_sticky", underflow, 1);
    while (!(m_on && m_p == 2 * HT + 10)) step(0, 1, 0, -1);
    step(0, 0, 0, -1);
    while (m_p != FR - 1) step(0, 0, 0, -1);
    step(0, 1, 0, -1);
    step(0, 1, 0, -1);
    chk("no_gap_fs", frame_start, 1);
    while (m_p != HT + 3) step(0, 1, 0, -1);
    while (m_on) step(0, 0, 0, -1);
    repeat (5) step(0, 0, 0, -1);
    chk("idle_busy", busy, 0);
    while (!(m_on && m_p == HT + 5)) step(0, 1, 2, -1);
    step(1, 1, 2, -1);
    step(0, 1, 2, -1);
    chk("rst_busy", busy, 0);
    chk("rst_hsync", vif.hsync, 1);
    chk("rst_underflow", underflow, 0);
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 2, -1);
`ifdef DVI_TEST_PATTERN_EN
    @(negedge clk);
    tp_sel = 1'b1;
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < HT + 3; i++) begin
      @(negedge clk);
      #1;
      chk("tp_req", vif.pix_req, 0);
      if (vif.vde && (vif.x_pos == 0 || vif.x_pos == 2 || vif.x_pos == 14))
        chk("tp_bar", vif.rgb_out, vif.x_pos == 0 ? 24'hFFFFFF : vif.x_pos == 2 ? 24'hFFFF00 : 24'h000000);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
